// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data RAM with valid/ready requests; word-crossing accesses split into two word ops.
// Latency 1 for single-word or errored requests, 2 for split ones; req_ready drops only during the split bubble.
module data_mem_ctrl #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);
   localparam int IW = ADDR_W - 2;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SPLIT = 1'b1;

   logic [31:0] mem [DEPTH];

   logic [0:0]  state_q, state_d;
   logic        we_q, we_d, uns_q, uns_d;
   logic [1:0]  size_q, size_d, lane_q, lane_d;
   logic [IW-1:0] idx_hi_q, idx_hi_d;
   logic [3:0]  mask_hi_q, mask_hi_d;
   logic [31:0] wdat_hi_q, wdat_hi_d, rd_lo_q, rd_lo_d;
   logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   logic [1:0]  lane;
   logic [IW-1:0] idx;
   logic [IW:0] idx_hi_ext;
   logic [3:0]  byte_mask;
   logic [7:0]  mask_wide;
   logic [63:0] data_wide, rd_pair;
   logic [31:0] rd_single;
   logic        is_split, is_err, accept;
   logic        wr_en;
   logic [IW-1:0] wr_idx;
   logic [3:0]  wr_mask;
   logic [31:0] wr_dat;

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                          input logic uns);
      case (size)
         2'b00:   return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   assign lane       = req_addr[1:0];
   assign idx        = req_addr[ADDR_W-1:2];
   assign idx_hi_ext = {1'b0, idx} + {{IW{1'b0}}, 1'b1};
   assign req_ready  = (state_q == IDLE);
   assign accept     = req_valid && req_ready;

   always_comb begin
      case (req_size)
         2'b00:   byte_mask = 4'b0001;
         2'b01:   byte_mask = 4'b0011;
         default: byte_mask = 4'b1111;
      endcase
   end

   // The request is placed in an 8-byte window spanning this word and the next one.
   assign mask_wide = {4'b0, byte_mask} << lane;
   assign data_wide = {32'b0, req_wdata} << {lane, 3'b000};
   assign is_split  = |mask_wide[7:4];
   assign is_err    = (req_size == 2'b11) || (is_split && idx_hi_ext[IW]);
   assign rd_single = mem[idx] >> {lane, 3'b000};
   assign rd_pair   = {mem[idx_hi_q], rd_lo_q} >> {lane_q, 3'b000};

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      uns_d       = uns_q;
      size_d      = size_q;
      lane_d      = lane_q;
      idx_hi_d    = idx_hi_q;
      mask_hi_d   = mask_hi_q;
      wdat_hi_d   = wdat_hi_q;
      rd_lo_d     = rd_lo_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'b0;
      wr_en       = 1'b0;
      wr_idx      = idx;
      wr_mask     = mask_wide[3:0];
      wr_dat      = data_wide[31:0];
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (is_split) begin
                  state_d   = SPLIT;
                  wr_en     = req_we;
                  we_d      = req_we;
                  uns_d     = req_unsigned;
                  size_d    = req_size;
                  lane_d    = lane;
                  idx_hi_d  = idx_hi_ext[IW-1:0];
                  mask_hi_d = mask_wide[7:4];
                  wdat_hi_d = data_wide[63:32];
                  rd_lo_d   = mem[idx];
               end else begin
                  rsp_valid_d = 1'b1;
                  wr_en       = req_we;
                  if (!req_we) rsp_rdata_d = extend(rd_single, req_size, req_unsigned);
               end
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            wr_en       = we_q;
            wr_idx      = idx_hi_q;
            wr_mask     = mask_hi_q;
            wr_dat      = wdat_hi_q;
            if (!we_q) rsp_rdata_d = extend(rd_pair[31:0], size_q, uns_q);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= 2'b0;
         lane_q      <= 2'b0;
         idx_hi_q    <= '0;
         mask_hi_q   <= 4'b0;
         wdat_hi_q   <= 32'b0;
         rd_lo_q     <= 32'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         uns_q       <= uns_d;
         size_q      <= size_d;
         lane_q      <= lane_d;
         idx_hi_q    <= idx_hi_d;
         mask_hi_q   <= mask_hi_d;
         wdat_hi_q   <= wdat_hi_d;
         rd_lo_q     <= rd_lo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Array is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: byte-level memory model plus a scoreboard queue of expected responses.
module tb_data_mem_ctrl;
   localparam int DEPTH = 32;
   localparam int AW    = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid, rsp_err;
   logic [31:0]   rsp_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       tag;
   } exp_t;

   exp_t        sb [$];
   logic [7:0]  bm [4*DEPTH];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   exp_t e_mon;
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e_mon = sb.pop_front();
            chk({e_mon.tag, "_rdata"}, rsp_rdata, e_mon.rdata);
            chk({e_mon.tag, "_err"}, 32'(rsp_err), 32'(e_mon.err));
            chk({e_mon.tag, "_cycle"}, 32'(cyc), 32'(e_mon.cyc));
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the response slot opens.
   task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input int addr, input logic [31:0] wd,
                         input bit use_c, input logic [31:0] cval);
      int nb;
      bit err, spl;
      logic [31:0] raw, msk;
      exp_t e;
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      err = (sz == 2'b11) || (addr + nb - 1 >= 4*DEPTH);
      spl = !err && ((addr % 4) + nb > 4);
      chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
      raw = 32'b0;
      if (!err) begin
         for (int k = 0; k < nb; k++) begin
            if (we) bm[addr+k] = wd[8*k +: 8];
            else    raw[8*k +: 8] = bm[addr+k];
         end
         if (!we && nb < 4) begin
            msk = (32'h1 << (8*nb)) - 32'h1;
            raw = raw & msk;
            if (!uns && raw[8*nb-1]) raw = raw | ~msk;
         end
      end
      if (use_c) raw = cval;
      e.rdata = raw;
      e.err   = err;
      e.cyc   = cyc + (spl ? 2 : 1);
      e.tag   = tag;
      sb.push_back(e);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr[AW-1:0];
      req_wdata    = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (spl) begin
         chk({tag, "_bubble"}, 32'(req_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = 32'b0;
      for (int i = 0; i < 4*DEPTH; i++) bm[i] = 8'h00;
      #12;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int w = 0; w < DEPTH; w++) do_req("clr", 1, 2'b10, 0, 4*w, 32'h0, 0, 0);

      do_req("st_w08", 1, 2'b10, 0, 8'h08, 32'hDEADBEEF, 1, 32'h0);
      do_req("ld_w08", 0, 2'b10, 0, 8'h08, 32'h0, 1, 32'hDEADBEEF);

      do_req("st_b0d", 1, 2'b00, 0, 8'h0D, 32'h00000080, 1, 32'h0);
      do_req("ld_bs0d", 0, 2'b00, 0, 8'h0D, 32'h0, 1, 32'hFFFFFF80);
      do_req("ld_bu0d", 0, 2'b00, 1, 8'h0D, 32'h0, 1, 32'h00000080);
      do_req("ld_w0c", 0, 2'b10, 0, 8'h0C, 32'h0, 1, 32'h00008000);

      do_req("clr04", 1, 2'b10, 0, 8'h04, 32'h0, 0, 0);
      do_req("clr08", 1, 2'b10, 0, 8'h08, 32'h0, 0, 0);
      do_req("st_w06", 1, 2'b10, 0, 8'h06, 32'h11223344, 1, 32'h0);
      do_req("ld_w04", 0, 2'b10, 0, 8'h04, 32'h0, 1, 32'h33440000);
      do_req("ld_w08b", 0, 2'b10, 0, 8'h08, 32'h0, 1, 32'h00001122);
      do_req("ld_w06", 0, 2'b10, 0, 8'h06, 32'h0, 1, 32'h11223344);
      do_req("ld_hs07", 0, 2'b01, 0, 8'h07, 32'h0, 1, 32'h00002233);
      do_req("st_h03", 1, 2'b01, 0, 8'h03, 32'h0000F0A5, 0, 0);
      do_req("ld_hs03", 0, 2'b01, 0, 8'h03, 32'h0, 1, 32'hFFFFF0A5);
      do_req("ld_hu03", 0, 2'b01, 1, 8'h03, 32'h0, 1, 32'h0000F0A5);

      do_req("ld_h7f", 0, 2'b01, 0, 8'h7F, 32'h0, 1, 32'h0);
      do_req("st_w00", 1, 2'b10, 0, 8'h00, 32'hCAFEF00D, 1, 32'h0);
      do_req("st_sz3", 1, 2'b11, 0, 8'h00, 32'hFFFFFFFF, 1, 32'h0);
      do_req("ld_w00", 0, 2'b10, 0, 8'h00, 32'h0, 1, 32'hCAFEF00D);

      do_req("clr0c", 1, 2'b10, 0, 8'h0C, 32'h0, 0, 0);
      do_req("clr10", 1, 2'b10, 0, 8'h10, 32'h0, 0, 0);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 7'h0F; req_wdata = 32'h0000ABCD;
      bm[15] = 8'hCD;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("split_rdy", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_valid_a", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_valid_b", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      chk("abort_rdy", 32'(req_ready), 32'd1);
      do_req("ld_w0c_ab", 0, 2'b10, 0, 8'h0C, 32'h0, 1, 32'hCD000000);
      do_req("ld_w10_ab", 0, 2'b10, 0, 8'h10, 32'h0, 1, 32'h00000000);

      do_req("b2b_0", 1, 2'b10, 0, 8'h00, 32'hA1A1A1A1, 1, 32'h0);
      do_req("b2b_4", 1, 2'b10, 0, 8'h04, 32'hB2B2B2B2, 1, 32'h0);
      do_req("b2b_8", 1, 2'b10, 0, 8'h08, 32'hC3C3C3C3, 1, 32'h0);
      do_req("b2b_ld0", 0, 2'b10, 0, 8'h00, 32'h0, 1, 32'hA1A1A1A1);
      do_req("b2b_ld4", 0, 2'b10, 0, 8'h04, 32'h0, 1, 32'hB2B2B2B2);
      do_req("b2b_ld8", 0, 2'b10, 0, 8'h08, 32'h0, 1, 32'hC3C3C3C3);
      do_req("ld_b0a", 0, 2'b00, 0, 8'h0A, 32'h0, 0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
